card_queue_server: RTL and testbench

- Responder side of the deck-operation interface used by the game controller.
- Owns every card deck as a circular FIFO in one internal synchronous-read RAM, one region per deck: source deck, player deck, com deck.
- Serves one operation at a time (POP, PUSH, PEEK, FILL) through a start/finished_op handshake, returning the card, the deck count and an error flag.

---
 rtl/card_queue_server.sv | 237 +++++++++++++++++++++++
 tb/tb_card_queue_server.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/card_queue_server.sv
// Deck-operation responder: every deck is a circular FIFO kept in one shared
// synchronous-read RAM, one DECK_CAP-entry region per deck. It serves one
// POP/PUSH/PEEK/FILL at a time and pulses finished_op on completion.
module card_queue_server #(
  parameter int unsigned NUM_DECKS = 3,
  parameter int unsigned DECK_CAP  = 64,
  parameter int unsigned CARD_W    = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [1:0]        deck_sel,
  input  logic [CARD_W-1:0] card_in,
  output logic              busy,
  output logic              finished_op,
  output logic              error,
  output logic [CARD_W-1:0] card_out,
  output logic [6:0]        count_out
);

  localparam int unsigned PTR_W     = $clog2(DECK_CAP);
  localparam int unsigned ADDR_W    = 2 + PTR_W;
  localparam int unsigned MEM_DEPTH = NUM_DECKS * DECK_CAP;
  localparam int unsigned FILL_N    = 52;

  typedef enum logic [1:0] {
    OpPop  = 2'd0,
    OpPush = 2'd1,
    OpPeek = 2'd2,
    OpFill = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StResp,
    StFill,
    StDone
  } state_e;

  state_e r_state, w_state_d;

  logic [PTR_W-1:0]  r_head  [NUM_DECKS];
  logic [PTR_W-1:0]  r_tail  [NUM_DECKS];
  logic [6:0]        r_count [NUM_DECKS];

  logic [CARD_W-1:0] r_mem [MEM_DEPTH];
  logic [CARD_W-1:0] r_ram_q;
  logic [CARD_W-1:0] r_rd_q;

  logic [1:0]        r_op;
  logic [1:0]        r_deck;
  logic              r_err;
  logic [PTR_W-1:0]  r_idx;
  logic [3:0]        r_rank;
  logic [1:0]        r_suit;

  logic              w_in_ok, w_cur_ok;
  logic [PTR_W-1:0]  w_in_head, w_in_tail, w_cur_head;
  logic [6:0]        w_in_cnt, w_cur_cnt;
  logic              w_in_rd, w_acc_err, w_accept, w_push_ok, w_fill_last;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr, w_raddr;
  logic [CARD_W-1:0] w_wdata;

  // Per-deck lookups for the requested deck (inputs) and the latched deck.
  always_comb begin
    w_in_ok    = 1'b0;
    w_in_head  = '0;
    w_in_tail  = '0;
    w_in_cnt   = '0;
    w_cur_ok   = 1'b0;
    w_cur_head = '0;
    w_cur_cnt  = '0;
    for (int unsigned i = 0; i < NUM_DECKS; i++) begin
      if (32'(deck_sel) == i) begin
        w_in_ok   = 1'b1;
        w_in_head = r_head[i];
        w_in_tail = r_tail[i];
        w_in_cnt  = r_count[i];
      end
      if (32'(r_deck) == i) begin
        w_cur_ok   = 1'b1;
        w_cur_head = r_head[i];
        w_cur_cnt  = r_count[i];
      end
    end
  end

  // Request decode and RAM port steering.
  always_comb begin
    w_in_rd     = (op == OpPop) || (op == OpPeek);
    w_acc_err   = !w_in_ok ||
                  (w_in_rd && (w_in_cnt == 7'd0)) ||
                  ((op == OpPush) && (w_in_cnt == 7'(DECK_CAP)));
    w_accept    = (r_state == StIdle) && start;
    w_push_ok   = w_accept && (op == OpPush) && !w_acc_err;
    w_fill_last = (r_idx == PTR_W'(FILL_N - 1));
    w_we        = w_push_ok || (r_state == StFill);
    if (r_state == StFill) begin
      w_waddr = {r_deck, r_idx};
      w_wdata = {{(CARD_W - 6){1'b0}}, r_suit, r_rank};
    end else begin
      w_waddr = {deck_sel, w_in_tail};
      w_wdata = card_in;
    end
    // Read address stays on the head of the target deck until RESP consumes it.
    if (r_state == StIdle) begin
      w_raddr = {deck_sel, w_in_head};
    end else begin
      w_raddr = {r_deck, w_cur_head};
    end
  end

  // Shared deck RAM: one write port, registered read port, never cleared.
  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
    r_ram_q <= r_mem[w_raddr];
  end

  // FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next-state and busy flag.
  always_comb begin
    w_state_d = r_state;
    busy      = (r_state != StIdle);
    case (r_state)
      StIdle: begin
        if (start) begin
          if (w_acc_err || (op == OpPush)) begin
            w_state_d = StDone;
          end else if (w_in_rd) begin
            w_state_d = StRd;
          end else begin
            w_state_d = StFill;
          end
        end
      end
      StRd:    w_state_d = StResp;
      StResp:  w_state_d = StDone;
      StFill:  w_state_d = w_fill_last ? StDone : StFill;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Datapath: request latch, deck pointers/counts, fill generator, outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_DECKS; i++) begin
        r_head[i]  <= '0;
        r_tail[i]  <= '0;
        r_count[i] <= '0;
      end
      r_op        <= '0;
      r_deck      <= '0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_rank      <= 4'd1;
      r_suit      <= '0;
      r_rd_q      <= '0;
      finished_op <= 1'b0;
      error       <= 1'b0;
      card_out    <= '0;
      count_out   <= '0;
    end else begin
      finished_op <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_op   <= op;
            r_deck <= deck_sel;
            r_err  <= w_acc_err;
            r_idx  <= '0;
            r_rank <= 4'd1;
            r_suit <= '0;
            if (w_acc_err && w_in_rd) begin
              card_out <= '0;
            end
            for (int unsigned i = 0; i < NUM_DECKS; i++) begin
              if (w_push_ok && (32'(deck_sel) == i)) begin
                r_tail[i]  <= r_tail[i] + 1'b1;
                r_count[i] <= r_count[i] + 1'b1;
              end
            end
          end
        end
        StRd: begin
          r_rd_q <= r_ram_q;
        end
        StResp: begin
          card_out <= r_rd_q;
          for (int unsigned i = 0; i < NUM_DECKS; i++) begin
            if ((r_op == OpPop) && (32'(r_deck) == i)) begin
              r_head[i]  <= r_head[i] + 1'b1;
              r_count[i] <= r_count[i] - 1'b1;
            end
          end
        end
        StFill: begin
          r_idx <= r_idx + 1'b1;
          // Rank/suit counters track idx%13+1 and idx/13 without a divider.
          if (r_rank == 4'd13) begin
            r_rank <= 4'd1;
            r_suit <= r_suit + 1'b1;
          end else begin
            r_rank <= r_rank + 1'b1;
          end
          for (int unsigned i = 0; i < NUM_DECKS; i++) begin
            if (w_fill_last && (32'(r_deck) == i)) begin
              r_head[i]  <= '0;
              r_tail[i]  <= PTR_W'(FILL_N);
              r_count[i] <= 7'(FILL_N);
            end
          end
        end
        StDone: begin
          finished_op <= 1'b1;
          error       <= r_err;
          count_out   <= w_cur_ok ? w_cur_cnt : 7'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_card_queue_server.sv
// Self-checking bench for card_queue_server: a queue-per-deck model predicts
// every completion; directed scenarios plus randomized traffic.
module tb_card_queue_server;

  logic       clock    = 1'b0;
  logic       resetn   = 1'b1;
  logic       start    = 1'b0;
  logic [1:0] op       = 2'd0;
  logic [1:0] deck_sel = 2'd0;
  logic [7:0] card_in  = 8'd0;
  logic       busy, finished_op, error;
  logic [7:0] card_out;
  logic [6:0] count_out;

  card_queue_server #(
    .NUM_DECKS(3),
    .DECK_CAP (64),
    .CARD_W   (8)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .op         (op),
    .deck_sel   (deck_sel),
    .card_in    (card_in),
    .busy       (busy),
    .finished_op(finished_op),
    .error      (error),
    .card_out   (card_out),
    .count_out  (count_out)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural model: one FIFO per deck.
  logic [7:0] mq [3][$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  logic        exp_pending = 1'b0;
  int unsigned exp_acc = 0;
  int          exp_lat = 0;
  logic        exp_err = 1'b0;
  logic [6:0]  exp_cnt = '0;
  logic        exp_cnt_en = 1'b0;
  logic [7:0]  exp_card = '0;
  logic        exp_card_en = 1'b0;
  int          lit_card = -1;
  int          lit_cnt = -1;
  int          lit_err = -1;
  logic        idle_expected = 1'b0;
  logic        rst_probe = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Single compare process: outputs during reset, completions, busy, timeouts.
  always @(negedge clock or posedge rst_probe) begin
    if (!resetn) begin
      chk("rst_busy", int'(busy), 0);
      chk("rst_finished", int'(finished_op), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_card_out", int'(card_out), 0);
      chk("rst_count_out", int'(count_out), 0);
    end else begin
      if (finished_op) begin
        if (!exp_pending) begin
          chk("finished_unexpected", int'(finished_op), int'(exp_pending));
        end else begin
          chk("latency", int'(cyc - exp_acc), exp_lat);
          chk("error", int'(error), int'(exp_err));
          if (exp_cnt_en)  chk("count_out", int'(count_out), int'(exp_cnt));
          if (exp_card_en) chk("card_out", int'(card_out), int'(exp_card));
          if (lit_card >= 0) chk("lit_card", int'(card_out), lit_card);
          if (lit_cnt >= 0)  chk("lit_count", int'(count_out), lit_cnt);
          if (lit_err >= 0)  chk("lit_error", int'(error), lit_err);
          done_cnt++;
        end
      end else if (exp_pending) begin
        chk("busy", int'(busy), 1);
        if (int'(cyc - exp_acc) > exp_lat + 8) begin
          chk("finished_timeout", int'(cyc - exp_acc), exp_lat);
          done_cnt++;
        end
      end
      if (idle_expected) chk("idle_busy", int'(busy), 0);
    end
  end

  // Predict one operation from the model, issue it, wait for its completion.
  // poke_at >= 0 re-asserts start (as a PUSH to deck 1) that many cycles after
  // acceptance; the DUT is busy then and must ignore it.
  task automatic run_op(input logic [1:0] o, input logic [1:0] d, input logic [7:0] c,
                        input int poke_at, input int l_card, input int l_cnt, input int l_err);
    logic       e_err, e_cnt_en, e_card_en;
    logic [6:0] e_cnt;
    logic [7:0] e_card;
    int         e_lat, k, target;
    e_err = 1'b0; e_lat = 1; e_cnt = '0; e_cnt_en = 1'b1; e_card = '0; e_card_en = 1'b0;
    if (d == 2'd3) begin
      e_err = 1'b1;
      e_cnt_en = 1'b0;
    end else begin
      case (o)
        2'd0, 2'd2: begin
          e_card_en = 1'b1;
          if (mq[d].size() == 0) begin
            e_err = 1'b1;
          end else begin
            e_lat  = 3;
            e_card = mq[d][0];
            if (o == 2'd0) void'(mq[d].pop_front());
          end
          e_cnt = 7'(mq[d].size());
        end
        2'd1: begin
          if (mq[d].size() == 64) e_err = 1'b1;
          else mq[d].push_back(c);
          e_cnt = 7'(mq[d].size());
        end
        default: begin
          mq[d].delete();
          for (int i = 0; i < 52; i++) mq[d].push_back(8'(((i / 13) << 4) | (i % 13 + 1)));
          e_lat = 53;
          e_cnt = 7'd52;
        end
      endcase
    end
    @(negedge clock);
    op = o; deck_sel = d; card_in = c; start = 1'b1;
    exp_err = e_err; exp_lat = e_lat; exp_cnt = e_cnt; exp_cnt_en = e_cnt_en;
    exp_card = e_card; exp_card_en = e_card_en;
    lit_card = l_card; lit_cnt = l_cnt; lit_err = l_err;
    @(negedge clock);
    exp_acc = cyc;
    target = done_cnt + 1;
    exp_pending = 1'b1;
    if (poke_at == 0) begin
      op = 2'd1; deck_sel = 2'd1; card_in = 8'hEE;
    end else begin
      start = 1'b0;
    end
    k = 0;
    while (done_cnt != target) begin
      @(negedge clock);
      k++;
      if (k == poke_at) begin
        start = 1'b1; op = 2'd1; deck_sel = 2'd1; card_in = 8'hEE;
      end else begin
        start = 1'b0;
      end
      #1;
      if (k > 200) begin
        $display("FAIL run_op_stuck: got no completion, want one within 200 cycles");
        $fatal(1);
      end
    end
    start = 1'b0;
    exp_pending = 1'b0;
  endtask

  initial begin
    #1 resetn = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;

    // Empty deck PEEK: immediate error, card and count 0.
    run_op(2'd2, 2'd0, 8'h00, -1, 8'h00, 0, 1);

    // FILL deck 0 then three POPs: ace, two, three of suit 0.
    run_op(2'd3, 2'd0, 8'h00, -1, -1, 52, 0);
    run_op(2'd0, 2'd0, 8'h00, -1, 8'h01, 51, 0);
    run_op(2'd0, 2'd0, 8'h00, -1, 8'h02, 50, 0);
    run_op(2'd0, 2'd0, 8'h00, -1, 8'h03, 49, 0);

    // Deck 1 FIFO order, underflow, and deck 0 left alone (49 after its 3 POPs).
    run_op(2'd1, 2'd1, 8'h2D, -1, -1, 1, 0);
    run_op(2'd1, 2'd1, 8'h31, -1, -1, 2, 0);
    run_op(2'd0, 2'd1, 8'h00, -1, 8'h2D, 1, 0);
    run_op(2'd0, 2'd1, 8'h00, -1, 8'h31, 0, 0);
    run_op(2'd0, 2'd1, 8'h00, -1, 8'h00, 0, 1);
    run_op(2'd2, 2'd0, 8'h00, -1, 8'h04, 49, 0);

    // Deck 2: fill to capacity, overflow, drain and wrap the tail.
    run_op(2'd3, 2'd2, 8'h00, -1, -1, 52, 0);
    for (int i = 0; i < 12; i++) run_op(2'd1, 2'd2, 8'($urandom_range(0, 255)), -1, -1, 53 + i, 0);
    run_op(2'd1, 2'd2, 8'hFF, -1, -1, 64, 1);
    for (int i = 0; i < 60; i++) run_op(2'd0, 2'd2, 8'h00, -1, -1, -1, -1);
    for (int i = 0; i < 5; i++) run_op(2'd1, 2'd2, 8'(8'h11 + i), -1, -1, 5 + i, 0);
    for (int i = 0; i < 9; i++) run_op(2'd0, 2'd2, 8'h00, -1, (i == 8) ? 8'h15 : -1, 8 - i, 0);

    // Starts while busy (during FILL and during RD) must be ignored.
    run_op(2'd3, 2'd1, 8'h00, 10, -1, 52, 0);
    run_op(2'd0, 2'd1, 8'h00, 0, 8'h01, 51, 0);
    run_op(2'd2, 2'd1, 8'h00, -1, 8'h02, 51, 0);

    // Reset in the middle of a FILL (idx 20): outputs clear asynchronously.
    @(negedge clock);
    op = 2'd3; deck_sel = 2'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (20) @(negedge clock);
    #2 resetn = 1'b0;
    mq[0].delete(); mq[1].delete(); mq[2].delete();
    #1 rst_probe = 1'b1;
    #1 rst_probe = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    idle_expected = 1'b1;
    repeat (4) @(negedge clock);
    idle_expected = 1'b0;
    run_op(2'd0, 2'd0, 8'h00, -1, 8'h00, 0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 200; i++) begin
      int unsigned r;
      logic [1:0]  o, d;
      r = $urandom_range(0, 99);
      if (r < 4)       o = 2'd3;
      else if (r < 50) o = 2'd1;
      else if (r < 80) o = 2'd0;
      else             o = 2'd2;
      d = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      run_op(o, d, 8'($urandom_range(0, 255)), -1, -1, -1, -1);
    end

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
